// File: rtl/reg_dump_reader.sv
// rtl/reg_dump_reader.sv - sequential register-file dump engine with valid/ready output
//
// Walks register addresses 0..NUM_REGS-1 on a dedicated register-file read
// port after a start pulse and streams each word out one beat at a time.
// Optional feature macro: REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-low reset
//   start_i               begin a dump (honoured only while idle)
//   busy_o                dump in progress
//   rd_addr_o, rd_data_i  register-file read port (data is combinational)
//   dump_valid_o/ready_i  beat handshake
//   dump_addr_o/data_o    register address and value of the current beat
//   dump_last_o           final beat of the dump
//   done_o                one-cycle pulse after the final beat is accepted
module reg_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t              state_q, state_d;
  logic                start_q, start_d;   // start accepted, FETCH begins next cycle
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d = '0;
`endif
        if (start_q) begin
          start_d = 1'b0;
          state_d = S_FETCH;
        end else begin
          start_d = start_i;
        end
      end
      S_FETCH: begin
        valid_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = rd_data_i;
`ifdef REG_DUMP_CHECKSUM_EN
        last_d  = 1'b0;   // the checksum beat carries last instead
        csum_d  = csum_q ^ rd_data_i;
`else
        last_d  = (cnt_q == LAST_ADDR);
`endif
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (dump_ready_i) begin
          // Outputs return to zero between beats so idle/DONE cycles read clean.
          valid_d = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          last_d  = 1'b0;
          if (cnt_q != LAST_ADDR) begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = S_FETCH;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            valid_d = 1'b1;
            data_d  = csum_q;
            last_d  = 1'b1;
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (dump_ready_i) begin
          valid_d = 1'b0;
          data_d  = '0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign busy_o       = start_q || (state_q != S_IDLE);
  assign rd_addr_o    = cnt_q;
  assign dump_valid_o = valid_q;
  assign dump_addr_o  = addr_q;
  assign dump_data_o  = data_q;
  assign dump_last_o  = last_q;
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb/tb_reg_dump_reader.sv - randomized self-checking bench for reg_dump_reader
module tb_reg_dump_reader;
  localparam int N = 32;
`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        dump_ready_i = 1'b0;
  logic        busy_o, dump_valid_o, dump_last_o, done_o;
  logic [4:0]  rd_addr_o, dump_addr_o;
  logic [31:0] rd_data_i, dump_data_o;

  logic [31:0] regs [N];
  logic        byp_en = 1'b0;
  logic [31:0] byp_data = 32'hA5A5A5A5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Register-file read port with a write bypass onto r20.
  always_comb rd_data_i = (byp_en && rd_addr_o == 5'd20) ? byp_data : regs[rd_addr_o];

  reg_dump_reader dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
    .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i),
    .dump_addr_o(dump_addr_o), .dump_data_o(dump_data_o),
    .dump_last_o(dump_last_o), .done_o(done_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_rd_addr"}, rd_addr_o, 0);
    chk({tag, "_valid"}, dump_valid_o, 0);
    chk({tag, "_addr"}, dump_addr_o, 0);
    chk({tag, "_data"}, dump_data_o, 0);
    chk({tag, "_last"}, dump_last_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  // mode: 0 plain, 1 stall beat 7, 2 restart pulse at beat 10, 3 reset at beat 15, 4 bypass r20
  task automatic run_dump(input int mode, input bit rand_ready);
    logic [31:0] exp [N];
    logic [31:0] xsum;
    int idx, n, stalls, dones, done_n, first_valid, stall_left, nbeats;
    bit prev_hs, prev_stall, hs, stall_started, rst_pend, finished;
    xsum = 0;
    for (int i = 0; i < N; i++) begin
      exp[i] = (mode == 4 && i == 20) ? byp_data : regs[i];
      xsum ^= exp[i];
    end
    nbeats = CSUM ? N + 1 : N;
    idx = 0; n = 0; stalls = 0; dones = 0; done_n = -1; first_valid = -1;
    stall_left = 0; prev_hs = 0; prev_stall = 0; stall_started = 0; rst_pend = 0; finished = 0;

    @(negedge clk);
    start_i = 1'b1;
    dump_ready_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;

    while (n < 400 && !finished) begin
      @(negedge clk);
      start_i = 1'b0;
      byp_en = 1'b0;
      hs = 0;
      if (rst_pend) begin
        chk_all_zero("abort");
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("abort_no_done", done_o, 0);
          chk("abort_idle_busy", busy_o, 0);
        end
        return;
      end
      if (done_o) begin
        dones++;
        done_n = n;
      end
      if (dones > 0 && n == done_n + 1) begin
        chk("idle_busy", busy_o, 0);
        chk("done_single", done_o, 0);
        finished = 1;
      end else begin
        if (prev_hs && idx < N) chk("gap_valid", dump_valid_o, 0);
        if (prev_stall) chk("hold_valid", dump_valid_o, 1);
        prev_stall = 0;
        if (dump_valid_o) begin
          if (first_valid < 0) first_valid = n;
          chk($sformatf("addr_b%0d", idx), dump_addr_o, (idx < N) ? idx : 0);
          chk($sformatf("data_b%0d", idx), dump_data_o, (idx < N) ? exp[idx] : xsum);
          chk($sformatf("last_b%0d", idx), dump_last_o, CSUM ? (idx == N) : (idx == N - 1));
          if (mode == 1 && idx == 7 && !stall_started) begin
            stall_started = 1;
            stall_left = 5;
          end
          if (stall_left > 0) begin
            dump_ready_i = 1'b0;
            stall_left--;
          end else if (rand_ready) begin
            dump_ready_i = $urandom_range(0, 1);
          end else begin
            dump_ready_i = 1'b1;
          end
          if (mode == 2 && idx == 10) start_i = 1'b1;
          if (mode == 3 && idx == 15) begin
            rst_i = 1'b0;
            rst_pend = 1;
          end else if (dump_ready_i) begin
            hs = 1;
            idx++;
          end else begin
            stalls++;
            prev_stall = 1;
          end
        end else begin
          dump_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
          if (mode == 4 && idx == 20 && busy_o && rd_addr_o == 5'd20) byp_en = 1'b1;
        end
      end
      prev_hs = hs;
      n++;
    end
    chk("first_valid_cycle", first_valid, 2);
    chk("beats", idx, nbeats);
    chk("done_count", dones, 1);
    chk("done_cycle", done_n, 65 + stalls + (CSUM ? 1 : 0));
  endtask

  initial begin
    for (int i = 0; i < N; i++) regs[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_i = 1'b1;
    @(negedge clk);
    chk_all_zero("idle");

    run_dump(0, 0);

    regs[1] = 32'h11111111; regs[2] = 32'h22222222; regs[31] = 32'hDEADBEEF;
    run_dump(0, 0);

    for (int t = 0; t < 7; t++) begin
      for (int i = 1; i < N; i++) regs[i] = $urandom;
      if (t == 0) regs[7] = 32'h77;
      case (t)
        0: run_dump(1, 0);
        1: run_dump(2, 0);
        2: run_dump(3, 0);
        3: run_dump(0, 0);
        4: run_dump(4, 0);
        default: run_dump(0, 1);
      endcase
      repeat (2) @(negedge clk);
      chk("between_busy", busy_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
